// File: rtl/matmul_pkg.sv
// Shared matmul definitions: default dimensions, accumulator width helper and
// the result-collector state encoding.
package matmul_pkg;

    function automatic int unsigned acc_bits(input int unsigned bits, input int unsigned depth);
        return 2 * bits + $clog2(depth);
    endfunction

    localparam int unsigned DEF_DEPTH    = 8;
    localparam int unsigned DEF_BITS     = 8;
    localparam int unsigned DEF_ACC_BITS = acc_bits(DEF_BITS, DEF_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } collect_state_t;

endpackage

// File: rtl/matrix_c_row_collect.sv
// One row of the result matrix: a DEPTH-entry store filled in column order,
// its fill counter, and full/overflow indications for the top-level FSM.
module matrix_c_row_collect
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ACC_BITS = DEF_ACC_BITS,
    parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CW       = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic [ACC_BITS-1:0] din_i,
    input  logic [AW-1:0]       rd_col_i,
    output logic [ACC_BITS-1:0] rd_data_c,
    output logic                full_c,
    output logic                ovf_c
);

    logic [ACC_BITS-1:0] mem_q [DEPTH];
    logic [CW-1:0]       cnt_q;
    logic                store_c;

    assign full_c  = (cnt_q == CW'(DEPTH));
    assign store_c = en_i & valid_i & ~full_c;
    // A valid beat arriving after the row already holds DEPTH elements is dropped.
    assign ovf_c   = en_i & valid_i & full_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (store_c) begin
            mem_q[cnt_q[AW-1:0]] <= din_i;
            cnt_q                <= cnt_q + CW'(1);
        end
    end

    // Columns beyond DEPTH only exist for non-power-of-2 sizes; they read as zero.
    assign rd_data_c = (CW'(rd_col_i) < CW'(DEPTH)) ? mem_q[rd_col_i] : '0;

endmodule

// File: rtl/matrix_c_collector.sv
// Result-matrix collector: captures C as the systolic array drains each row,
// then serves registered random-access reads once every row is complete.
module matrix_c_collector
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned BITS     = DEF_BITS,
    parameter int unsigned ACC_BITS = acc_bits(BITS, DEPTH),
    parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DEPTH-1:0]             c_valid,
    input  logic [DEPTH*ACC_BITS-1:0]    c_in,
    input  logic                         RdEn,
    input  logic [AW-1:0]                row,
    input  logic [AW-1:0]                col,
    output logic signed [ACC_BITS-1:0]   q,
    output logic                         q_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned CW = AW + 1;

    collect_state_t      state_q, state_d;
    logic                busy_q, done_q, err_q, q_valid_q;
    logic [ACC_BITS-1:0] q_q;

    logic [ACC_BITS-1:0] row_rd [DEPTH];
    logic [DEPTH-1:0]    full_c;
    logic [DEPTH-1:0]    ovf_c;
    logic                all_full_c;
    logic                capture_en_c;
    logic                rd_fire_c;
    logic [ACC_BITS-1:0] rd_sel_c;

    // A start in the same cycle as c_valid restarts the capture and drops that beat.
    assign capture_en_c = (state_q == COLLECT) && !start;
    assign all_full_c   = &full_c;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        matrix_c_row_collect #(
            .DEPTH    (DEPTH),
            .ACC_BITS (ACC_BITS),
            .AW       (AW),
            .CW       (CW)
        ) u_row (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (start),
            .en_i      (capture_en_c),
            .valid_i   (c_valid[gi]),
            .din_i     (c_in[gi*ACC_BITS +: ACC_BITS]),
            .rd_col_i  (col),
            .rd_data_c (row_rd[gi]),
            .full_c    (full_c[gi]),
            .ovf_c     (ovf_c[gi])
        );
    end

    assign rd_sel_c = (CW'(row) < CW'(DEPTH)) ? row_rd[row] : '0;

    // Next-state and read-issue decode; start overrides everything, including a read.
    always_comb begin
        state_d   = state_q;
        rd_fire_c = 1'b0;
        if (start) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                COLLECT: if (all_full_c) state_d = READY;
                READY:   rd_fire_c = RdEn;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            q_valid_q <= 1'b0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d == COLLECT);
            done_q    <= (state_d == READY);
            err_q     <= start ? 1'b0 : (err_q | (|ovf_c));
            q_valid_q <= rd_fire_c;
            if (rd_fire_c) begin
                q_q <= rd_sel_c;
            end
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_matrix_c_collector.sv
// Randomised bench for matrix_c_collector (DEPTH=4, ACC_BITS=18) against a
// behavioural model of the capture/read rules, plus pinned literal checks.
module tb_matrix_c_collector;

    localparam int unsigned D = 4;
    localparam int unsigned B = 8;
    localparam int unsigned A = 18;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start = 1'b0;
    logic [D-1:0]       c_valid = '0;
    logic [D*A-1:0]     c_in = '0;
    logic               RdEn = 1'b0;
    logic [1:0]         row = '0;
    logic [1:0]         col = '0;
    logic signed [A-1:0] q;
    logic               q_valid, busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0 = waiting, 1 = capturing, 2 = matrix complete.
    int m_mem [D][D];
    int m_n   [D];
    int m_phase = 0;
    int m_err = 0;
    int m_q = 0;
    int m_qv = 0;

    matrix_c_collector #(.DEPTH(D), .BITS(B), .ACC_BITS(A)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .c_valid (c_valid),
        .c_in    (c_in),
        .RdEn    (RdEn),
        .row     (row),
        .col     (col),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                m_n[i] = 0;
                for (int j = 0; j < D; j++) m_mem[i][j] = 0;
            end
            m_phase = 0; m_err = 0; m_q = 0; m_qv = 0;
        end else begin
            m_qv = 0;
            if (start) begin
                for (int i = 0; i < D; i++) m_n[i] = 0;
                m_err = 0;
                m_phase = 1;
            end else if (m_phase == 1) begin
                bit was_full;
                was_full = 1'b1;
                for (int i = 0; i < D; i++) if (m_n[i] != D) was_full = 1'b0;
                for (int i = 0; i < D; i++) begin
                    if (c_valid[i]) begin
                        if (m_n[i] < D) begin
                            m_mem[i][m_n[i]] = int'($signed(c_in[i*A +: A]));
                            m_n[i]++;
                        end else begin
                            m_err = 1;
                        end
                    end
                end
                if (was_full) m_phase = 2;
            end else if (m_phase == 2 && RdEn) begin
                m_q  = m_mem[row][col];
                m_qv = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("q",       int'(q),       m_q);
        chk("q_valid", int'(q_valid), m_qv);
        chk("busy",    int'(busy),    (m_phase == 1) ? 1 : 0);
        chk("done",    int'(done),    (m_phase == 2) ? 1 : 0);
        chk("err",     int'(err),     m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input int v);
        c_in[i*A +: A] = A'(v);
    endtask

    task automatic rd(input int r, input int c);
        row = 2'(r); col = 2'(c); RdEn = 1'b1;
        tick();
        RdEn = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < D; k++) begin
            c_valid = '1;
            for (int i = 0; i < D; i++) set_row(i, int'($urandom_range(0, 262143)) - 131072);
            tick();
        end
        c_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_qv", int'(q_valid), 0);
        #16 rst_n = 1'b1;
        tick();

        // Read in IDLE is ignored.
        rd(1, 1);
        chk("idle_rd_qv", int'(q_valid), 0);
        chk("idle_rd_q", int'(q), 0);

        // Aligned drain, c_in[i] = 10*i+k.
        do_start();
        for (int k = 0; k < D; k++) begin
            c_valid = '1;
            for (int i = 0; i < D; i++) set_row(i, 10 * i + k);
            tick();
        end
        c_valid = '0;
        chk("t1_done_late", int'(done), 0);
        tick();
        chk("t1_done", int'(done), 1);
        rd(2, 3);
        chk("t1_q23", int'(q), 23);
        chk("t1_qv", int'(q_valid), 1);

        // Skewed drain with negative values; row i starts i cycles late.
        do_start();
        for (int t = 0; t < 2 * D - 1; t++) begin
            c_valid = '0;
            for (int i = 0; i < D; i++) begin
                if (t >= i && t < i + D) begin
                    c_valid[i] = 1'b1;
                    set_row(i, -(10 * i + (t - i)));
                end
            end
            tick();
        end
        c_valid = '0;
        chk("t2_done_late", int'(done), 0);
        tick();
        chk("t2_done", int'(done), 1);
        rd(3, 0);
        chk("t2_q30", int'(q), -30);
        rd(0, 3);
        chk("t2_q3", int'(q), -3);

        // Row 1 fills early, then one extra beat of 99 overflows it.
        do_start();
        for (int t = 0; t < 6; t++) begin
            c_valid = '0;
            if (t < 4) begin
                c_valid[1] = 1'b1; set_row(1, 10 + t);
            end else if (t == 4) begin
                c_valid[1] = 1'b1; set_row(1, 99);
            end
            if (t >= 2) begin
                for (int i = 0; i < D; i++) begin
                    if (i != 1) begin
                        c_valid[i] = 1'b1; set_row(i, 10 * i + (t - 2));
                    end
                end
            end
            tick();
        end
        c_valid = '0;
        chk("t3_err", int'(err), 1);
        chk("t3_done_late", int'(done), 0);
        tick();
        chk("t3_done", int'(done), 1);
        rd(1, 3);
        chk("t3_q13", int'(q), 13);
        do_start();
        chk("t3_err_clr", int'(err), 0);
        chk("t3_busy", int'(busy), 1);

        // Read during COLLECT is ignored; start beats RdEn in READY.
        rd(0, 0);
        chk("t4_col_qv", int'(q_valid), 0);
        chk("t4_col_q", int'(q), 13);
        fill_random();
        tick();
        chk("t4_done", int'(done), 1);
        start = 1'b1;
        rd(2, 2);
        start = 1'b0;
        chk("t4_sr_qv", int'(q_valid), 0);
        chk("t4_sr_busy", int'(busy), 1);
        chk("t4_sr_q", int'(q), 13);

        // Asynchronous reset mid-capture.
        for (int k = 0; k < 2; k++) begin
            c_valid = '1;
            for (int i = 0; i < D; i++) set_row(i, int'($urandom_range(0, 1000)));
            tick();
        end
        c_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_q", int'(q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        fill_random();
        tick();
        chk("t5_done", int'(done), 1);

        // Back-to-back reads of every cell.
        RdEn = 1'b1;
        for (int a = 0; a < D * D; a++) begin
            row = 2'(a / D); col = 2'(a % D);
            tick();
            chk("t6_qv", int'(q_valid), 1);
            chk("t6_done", int'(done), 1);
        end
        RdEn = 1'b0;
        tick();

        // Random traffic: sporadic valids, reads and restarts.
        for (int it = 0; it < 6; it++) begin
            for (int cyc = 0; cyc < 300; cyc++) begin
                start   = (cyc == 0) || ($urandom_range(0, 79) == 0);
                c_valid = 4'($urandom);
                for (int i = 0; i < D; i++) set_row(i, int'($urandom_range(0, 262143)) - 131072);
                RdEn = 1'($urandom);
                row  = 2'($urandom);
                col  = 2'($urandom);
                tick();
            end
        end
        start = 1'b0; c_valid = '0; RdEn = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
